wb_mem_bridge: RTL

- Parametrised multi-channel bridge from core-native memory request ports (en/we/addr/data/strobe in; valid/data out) to registered Wishbone classic masters.
- One independent channel per core memory port, e.g. channel 0 = instruction fetch, channel 1 = data.
- Sits between the core and the Controller/testbench inside processorci_top.
- Replaces hard-wired cyc/stb=1 with real per-transaction cyc/stb framing, bus-error and timeout handling, an optional response register stage, and per-channel error counting.

---
 rtl/wb_mem_bridge.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wb_mem_bridge.sv
// wb_mem_bridge: per-channel bridge from core memory request ports to registered Wishbone classic masters.
// Each channel runs its own IDLE/BUS FSM with bus-error/timeout termination and a saturating error counter.
module wb_mem_bridge #(
  parameter int NUM_CH         = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_RESPONSE   = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERRCNT_WIDTH   = 16
) (
  input  logic                                 clk_core,
  input  logic                                 rst_core,
  input  logic [NUM_CH-1:0]                    req_en,
  input  logic [NUM_CH-1:0]                    req_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         req_wdata,
  input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]     req_strobe,
  output logic [NUM_CH-1:0]                    req_ready,
  output logic [NUM_CH-1:0]                    resp_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]         resp_data,
  output logic [NUM_CH-1:0]                    resp_err,
  output logic [NUM_CH*ERRCNT_WIDTH-1:0]       err_count,
  output logic [NUM_CH-1:0]                    wb_cyc,
  output logic [NUM_CH-1:0]                    wb_stb,
  output logic [NUM_CH-1:0]                    wb_we,
  output logic [NUM_CH*(DATA_WIDTH/8)-1:0]     wb_sel,
  output logic [NUM_CH*ADDR_WIDTH-1:0]         wb_adr,
  output logic [NUM_CH*DATA_WIDTH-1:0]         wb_dat_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         wb_dat_i,
  input  logic [NUM_CH-1:0]                    wb_ack,
  input  logic [NUM_CH-1:0]                    wb_err
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  typedef enum logic {IDLE, BUS} state_t;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    cyc_q, we_q;
    logic [SW-1:0]           sel_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic                    rv_q, re_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [ERRCNT_WIDTH-1:0] ec_q;
    logic                    tmo, done_d, fail_d;
    logic [DATA_WIDTH-1:0]   rd_d;
    // An ack on the timeout cycle wins; wb_err wins over everything.
    assign tmo    = (TIMEOUT_CYCLES != 0) && (cnt_q == TMAX);
    assign done_d = (state_q == BUS) && (wb_err[c] || wb_ack[c] || tmo);
    assign fail_d = wb_err[c] || (!wb_ack[c] && tmo);
    assign rd_d   = (fail_d || we_q) ? '0 : wb_dat_i[c*DATA_WIDTH +: DATA_WIDTH];
    always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        cyc_q   <= 1'b0;
        we_q    <= 1'b0;
        sel_q   <= '0;
        adr_q   <= '0;
        dat_q   <= '0;
        rv_q    <= 1'b0;
        re_q    <= 1'b0;
        rd_q    <= '0;
        ec_q    <= '0;
      end else begin
        rv_q <= done_d;
        if (done_d) begin
          re_q <= fail_d;
          rd_q <= rd_d;
          if (fail_d && !(&ec_q)) ec_q <= ec_q + 1'b1;
        end
        if (state_q == IDLE) begin
          if (req_en[c]) begin
            state_q <= BUS;
            cyc_q   <= 1'b1;
            we_q    <= req_we[c];
            adr_q   <= req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            dat_q   <= req_we[c] ? req_wdata[c*DATA_WIDTH +: DATA_WIDTH] : '0;
            sel_q   <= req_we[c] ? req_strobe[c*SW +: SW] : '1;
          end
        end else if (done_d) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          sel_q   <= '0;
          adr_q   <= '0;
          dat_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
    assign req_ready[c]                              = (state_q == IDLE);
    assign wb_cyc[c]                                 = cyc_q;
    assign wb_stb[c]                                 = cyc_q;
    assign wb_we[c]                                  = we_q;
    assign wb_sel[c*SW +: SW]                        = sel_q;
    assign wb_adr[c*ADDR_WIDTH +: ADDR_WIDTH]        = adr_q;
    assign wb_dat_o[c*DATA_WIDTH +: DATA_WIDTH]      = dat_q;
    assign err_count[c*ERRCNT_WIDTH +: ERRCNT_WIDTH] = ec_q;
    if (REG_RESPONSE != 0) begin : g_reg
      logic                  rv2_q, re2_q;
      logic [DATA_WIDTH-1:0] rd2_q;
      always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
          rv2_q <= 1'b0;
          re2_q <= 1'b0;
          rd2_q <= '0;
        end else begin
          rv2_q <= rv_q;
          if (rv_q) begin
            re2_q <= re_q;
            rd2_q <= rd_q;
          end
        end
      end
      assign resp_valid[c]                         = rv2_q;
      assign resp_err[c]                           = re2_q;
      assign resp_data[c*DATA_WIDTH +: DATA_WIDTH] = rd2_q;
    end else begin : g_direct
      assign resp_valid[c]                         = rv_q;
      assign resp_err[c]                           = re_q;
      assign resp_data[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end
  end
endmodule
